// File: rtl/router_fsm.sv
// router_fsm: 1x3 router packet-sequencing FSM; ROUTER_FSM_WAIT_TIMEOUT_EN adds a WAIT_TILL_EMPTY abort timer.
module router_fsm #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       timeout_err
);
  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } state_t;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..255");
  end
  state_t state, next;
  logic [1:0] addr_q;
  logic tgt_empty, tgt_soft, hdr_empty, tmo;
  assign tgt_empty = addr_q == 2'd0 ? fifo_empty_0 : addr_q == 2'd1 ? fifo_empty_1 :
                     addr_q == 2'd2 ? fifo_empty_2 : 1'b1;
  assign tgt_soft  = addr_q == 2'd0 ? soft_reset_0 : addr_q == 2'd1 ? soft_reset_1 :
                     addr_q == 2'd2 ? soft_reset_2 : 1'b0;
  // The header decision must use the incoming address, addr_q is only loaded on that same edge
  assign hdr_empty = data_in == 2'd0 ? fifo_empty_0 : data_in == 2'd1 ? fifo_empty_1 : fifo_empty_2;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic [7:0] cnt;
  logic       tmo_q;
  assign tmo = state == WAIT_TILL_EMPTY && !tgt_soft && !tgt_empty && cnt == 8'(TIMEOUT_CYCLES - 1);
  assign timeout_err = tmo_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 8'd0;
      tmo_q <= 1'b0;
    end else begin
      cnt   <= state == WAIT_TILL_EMPTY ? cnt + 8'd1 : 8'd0;
      tmo_q <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DECODE_ADDRESS;
      addr_q <= 2'd3;
    end else begin
      state <= next;
      if (state == DECODE_ADDRESS && pkt_valid) addr_q <= data_in;
    end
  end
  always_comb begin
    next = state;
    case (state)
      DECODE_ADDRESS:     if (pkt_valid && data_in != 2'd3) next = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:    if (tgt_empty) next = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    next = LOAD_DATA;
      LOAD_DATA:          next = fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    if (!fifo_full) next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    next = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            next = DECODE_ADDRESS;
    endcase
    if ((state != DECODE_ADDRESS && tgt_soft) || tmo) next = DECODE_ADDRESS;
  end
  assign detect_add    = state == DECODE_ADDRESS;
  assign lfd_state     = state == LOAD_FIRST_DATA;
  assign ld_state      = state == LOAD_DATA;
  assign laf_state     = state == LOAD_AFTER_FULL;
  assign full_state    = state == FIFO_FULL_STATE;
  assign rst_int_reg   = state == CHECK_PARITY_ERROR;
  assign write_enb_reg = state == LOAD_DATA || state == LOAD_AFTER_FULL || state == LOAD_PARITY;
  assign busy          = !(state == DECODE_ADDRESS || state == LOAD_DATA);
endmodule
